// File: rtl/ghrd_reset_pkg.sv
// Shared types and helpers for the GHRD reset sequencer.
// The state encoding, the reset-cause codes and the width helpers live here.
package ghrd_reset_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SW_HOLD   = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  function automatic int clog2(input longint unsigned value);
    int r;
    longint unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ghrd_sync_ff.sv
// N-stage flip-flop synchronizer with asynchronous active-low clear.
// Used both for the PLL lock input and for the reset-release path.
module ghrd_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ghrd_reset_sequencer.sv
// Reset sequencer feeding the Nios II SoC: qualifies board reset, PLL lock and
// software requests, and produces a minimum-width, synchronously released reset.
module ghrd_reset_sequencer
  import ghrd_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 1024,
  parameter int SW_PULSE_CYCLES = 256,
  parameter int LOCK_TIMEOUT    = 1048576,
  parameter int HB_BIT          = 25
) (
  input  logic       clk_50,
  input  logic       fpga_reset_n,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       system_reset_n,
  output logic [1:0] reset_cause,
  output logic       lock_fail,
  output logic       heartbeat_led
);

  localparam int CNT_W = clog2(longint'(max3(HOLD_CYCLES, SW_PULSE_CYCLES, LOCK_TIMEOUT))) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic [1:0]       cause, cause_nxt;
  logic             set_fail;
  logic             lock_s;
  logic             lock_fail_q;
  logic             req_q;
  logic             run_q;
  logic             rst_req;
  logic             rel_clr_n;
  logic             srn;
  logic [HB_BIT:0]  hb_cnt;

  // Lock qualification
  ghrd_sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk_50),
    .rst_n (fpga_reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // A RUN-state request drops the reset combinationally from flop outputs so the
  // SoC sees reset in the very cycle the request is raised; req_q holds it after.
  assign rst_req   = req_q | (run_q & (sw_reset_req | ~lock_s));
  assign rel_clr_n = fpga_reset_n & ~rst_req;

  ghrd_sync_ff #(.STAGES(SYNC_STAGES)) u_rel_sync (
    .clk   (clk_50),
    .rst_n (rel_clr_n),
    .d     (1'b1),
    .q     (srn)
  );

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cause_nxt = cause;
    set_fail  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (cnt == LOCK_LAST) set_fail = 1'b1;
        if (lock_s) begin
          cnt_clr   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          cnt_clr   = 1'b1;
          state_nxt = WAIT_LOCK;
        end else if (cnt == HOLD_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        cnt_clr   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        cnt_clr = 1'b1;
        if (!lock_s) begin
          cause_nxt = CAUSE_LOCK;
          state_nxt = WAIT_LOCK;
        end else if (sw_reset_req) begin
          cause_nxt = CAUSE_SW;
          state_nxt = SW_HOLD;
        end
      end
      SW_HOLD: begin
        if (!lock_s) begin
          cause_nxt = CAUSE_LOCK;
          cnt_clr   = 1'b1;
          state_nxt = WAIT_LOCK;
        end else if (cnt == SW_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = HOLD;
        end
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT_LOCK;
      end
    endcase
  end

  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      cause       <= CAUSE_POR;
      lock_fail_q <= 1'b0;
      req_q       <= 1'b1;
      run_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_clr ? '0 : sat_inc(cnt);
      cause       <= cause_nxt;
      lock_fail_q <= lock_fail_q | set_fail;
      req_q       <= !(state_nxt == RELEASE || state_nxt == RUN);
      run_q       <= (state_nxt == RUN);
    end
  end

  // Heartbeat only advances while the SoC is out of reset
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      hb_cnt <= '0;
    end else if (srn) begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  assign system_reset_n = srn;
  assign reset_cause    = cause;
  assign lock_fail      = lock_fail_q;
  assign heartbeat_led  = hb_cnt[HB_BIT];

endmodule

// File: tb/tb_ghrd_reset_sequencer.sv
// Directed bench for ghrd_reset_sequencer: power-on, lock glitch, software
// reset, simultaneous events, board reset mid-hold and lock timeout.
module tb_ghrd_reset_sequencer;

  localparam int HB = 3;

  logic       clk_50 = 1'b0;
  logic       fpga_reset_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       system_reset_n;
  logic [1:0] reset_cause;
  logic       lock_fail;
  logic       heartbeat_led;

  int total = 0;
  int bad = 0;
  int n;
  logic led_before;
  logic [HB:0] hb_model;

  ghrd_reset_sequencer #(
    .SYNC_STAGES     (2),
    .HOLD_CYCLES     (1024),
    .SW_PULSE_CYCLES (256),
    .LOCK_TIMEOUT    (64),
    .HB_BIT          (HB)
  ) dut (
    .clk_50         (clk_50),
    .fpga_reset_n   (fpga_reset_n),
    .pll_locked     (pll_locked),
    .sw_reset_req   (sw_reset_req),
    .system_reset_n (system_reset_n),
    .reset_cause    (reset_cause),
    .lock_fail      (lock_fail),
    .heartbeat_led  (heartbeat_led)
  );

  always #10 clk_50 = ~clk_50;

  // Heartbeat reference: counts cycles in which the SoC was out of reset
  always @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) hb_model <= '0;
    else if (system_reset_n) hb_model <= hb_model + 1'b1;
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk_50);
    #1;
  endtask

  task automatic wait_rise(input int limit, output int cnt);
    cnt = 0;
    while (system_reset_n !== 1'b1 && cnt < limit) begin
      cyc(1);
      cnt++;
    end
  endtask

  task automatic release_reset();
    @(negedge clk_50);
    fpga_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 fpga_reset_n = 1'b0;
    cyc(3);
    total++; if (system_reset_n !== 1'b0) begin bad++; $display("FAIL rst_srn: got %b want 0", system_reset_n); end
    total++; if (reset_cause !== 2'b00) begin bad++; $display("FAIL rst_cause: got %b want 00", reset_cause); end
    total++; if (lock_fail !== 1'b0) begin bad++; $display("FAIL rst_lock_fail: got %b want 0", lock_fail); end
    total++; if (heartbeat_led !== 1'b0) begin bad++; $display("FAIL rst_led: got %b want 0", heartbeat_led); end
    cyc(2);
  endtask

  // Lock raised after posedge N: 2 sync + 1 to HOLD + 1024 hold + 2 release sync
  task automatic test_power_on();
    release_reset();
    cyc(10);
    pll_locked = 1'b1;
    wait_rise(2000, n);
    total++; if (n != 1029) begin bad++; $display("FAIL por_rise: got %0d cycles want 1029", n); end
    total++; if (reset_cause !== 2'b00) begin bad++; $display("FAIL por_cause: got %b want 00", reset_cause); end
    total++; if (lock_fail !== 1'b0) begin bad++; $display("FAIL por_lock_fail: got %b want 0", lock_fail); end
  endtask

  task automatic test_lock_glitch();
    cyc(21);
    total++; if (heartbeat_led !== hb_model[HB]) begin bad++; $display("FAIL glitch_led_run: got %b want %b", heartbeat_led, hb_model[HB]); end
    pll_locked = 1'b0;
    cyc(1);
    total++; if (system_reset_n !== 1'b1) begin bad++; $display("FAIL glitch_srn_sync: got %b want 1", system_reset_n); end
    cyc(1);
    total++; if (system_reset_n !== 1'b0) begin bad++; $display("FAIL glitch_srn_low: got %b want 0", system_reset_n); end
    cyc(1);
    total++; if (reset_cause !== 2'b01) begin bad++; $display("FAIL glitch_cause: got %b want 01", reset_cause); end
    pll_locked = 1'b1;
    wait_rise(2000, n);
    total++; if (n != 1029) begin bad++; $display("FAIL glitch_rise: got %0d cycles want 1029", n); end
    total++; if (heartbeat_led !== hb_model[HB]) begin bad++; $display("FAIL glitch_led: got %b want %b", heartbeat_led, hb_model[HB]); end
  endtask

  task automatic test_sw_reset();
    cyc(13);
    led_before = heartbeat_led;
    sw_reset_req = 1'b1;
    #1;
    total++; if (system_reset_n !== 1'b0) begin bad++; $display("FAIL sw_srn_same_cycle: got %b want 0", system_reset_n); end
    cyc(1);
    sw_reset_req = 1'b0;
    total++; if (reset_cause !== 2'b10) begin bad++; $display("FAIL sw_cause: got %b want 10", reset_cause); end
    cyc(600);
    total++; if (heartbeat_led !== led_before) begin bad++; $display("FAIL sw_led_mid: got %b want %b", heartbeat_led, led_before); end
    wait_rise(2000, n);
    total++; if (n != 682) begin bad++; $display("FAIL sw_rise: got %0d cycles want 682", n); end
    total++; if (heartbeat_led !== led_before) begin bad++; $display("FAIL sw_led_frozen: got %b want %b", heartbeat_led, led_before); end
    total++; if (reset_cause !== 2'b10) begin bad++; $display("FAIL sw_cause_after: got %b want 10", reset_cause); end
  endtask

  task automatic test_simultaneous();
    cyc(17);
    pll_locked = 1'b0;
    cyc(2);
    sw_reset_req = 1'b1;
    cyc(1);
    sw_reset_req = 1'b0;
    total++; if (reset_cause !== 2'b01) begin bad++; $display("FAIL simul_cause: got %b want 01", reset_cause); end
    pll_locked = 1'b1;
    wait_rise(2000, n);
    total++; if (n != 1029) begin bad++; $display("FAIL simul_rise: got %0d cycles want 1029", n); end
  endtask

  task automatic test_reset_mid_hold();
    cyc(9);
    pll_locked = 1'b0;
    cyc(3);
    pll_locked = 1'b1;
    cyc(503);
    total++; if (system_reset_n !== 1'b0) begin bad++; $display("FAIL midhold_srn_pre: got %b want 0", system_reset_n); end
    fpga_reset_n = 1'b0;
    #1;
    total++; if (reset_cause !== 2'b00) begin bad++; $display("FAIL midhold_cause: got %b want 00", reset_cause); end
    total++; if (heartbeat_led !== 1'b0 || hb_model !== '0) begin bad++; $display("FAIL midhold_led: got %b want 0", heartbeat_led); end
    cyc(3);
    release_reset();
    cyc(100);
    sw_reset_req = 1'b1;
    cyc(1);
    sw_reset_req = 1'b0;
    wait_rise(2000, n);
    total++; if (n != 928) begin bad++; $display("FAIL midhold_rise: got %0d cycles want 928", n); end
    total++; if (reset_cause !== 2'b00) begin bad++; $display("FAIL midhold_cause_after: got %b want 00", reset_cause); end
  endtask

  // Counter reads k after the k-th edge; it equals 63 entering edge 64
  task automatic test_lock_timeout();
    pll_locked = 1'b0;
    fpga_reset_n = 1'b0;
    cyc(2);
    release_reset();
    cyc(63);
    total++; if (lock_fail !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", lock_fail); end
    cyc(1);
    total++; if (lock_fail !== 1'b1) begin bad++; $display("FAIL timeout_set: got %b want 1", lock_fail); end
    cyc(2100);
    total++; if (lock_fail !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", lock_fail); end
    pll_locked = 1'b1;
    wait_rise(2000, n);
    total++; if (n != 1029) begin bad++; $display("FAIL timeout_rise: got %0d cycles want 1029", n); end
    total++; if (lock_fail !== 1'b1) begin bad++; $display("FAIL timeout_after: got %b want 1", lock_fail); end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_lock_glitch();
    test_sw_reset();
    test_simultaneous();
    test_reset_mid_hold();
    test_lock_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
